// File: rtl/char_rx_pkg.sv
// Shared constants for the serial character receiver: state encoding,
// character width and the idle level of the serial line.
package char_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset
// to the line idle level so reset never looks like a start bit.
module rx_sync
  import char_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/char_uart_rx.sv
// 8N1 serial character receiver feeding the character-recognition FSM.
// Optional even-parity checking is enabled with CHAR_UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | timing to the middle of the start bit, rejecting glitches
// DATA   | sampling the eight data bits, LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit, publishing the character
// BREAK  | line held low after a framing error, waiting for idle
module char_uart_rx
  import char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
`ifdef CHAR_UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] TC_BIT  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t         state;
  rx_state_t         state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              rx_s;
  logic              tc_half;
  logic              tc_bit;
  logic              last_bit;
  logic              stop_smp;
  logic              par_bad;
  logic              ld_char;
  logic              ferr_set;
  logic              perr_set;

  rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign tc_half  = (cnt == TC_HALF);
  assign tc_bit   = (cnt == TC_BIT);
  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (!rx_s) state_nx = START;
      START:  if (tc_half) state_nx = rx_s ? IDLE : DATA;
`ifdef CHAR_UART_RX_PARITY_EN
      DATA:   if (tc_bit && last_bit) state_nx = PARITY;
      PARITY: if (tc_bit) state_nx = STOP;
`else
      DATA:   if (tc_bit && last_bit) state_nx = STOP;
`endif
      STOP:   if (tc_bit) state_nx = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef CHAR_UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          par_bit <= 1'b0;
    else if (state == PARITY && tc_bit)  par_bit <= rx_s;
  end

  assign par_bad = (^shreg) ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  // Framing is checked first: a bad stop bit suppresses any parity report.
  always_comb begin
    stop_smp = (state == STOP) && tc_bit;
    ferr_set = stop_smp && !rx_s;
    ld_char  = stop_smp && rx_s && !par_bad;
    perr_set = stop_smp && rx_s && par_bad;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        START: begin
          cnt <= tc_half ? '0 : cnt + CNT_W'(1);
          if (tc_half) bit_idx <= '0;
        end
        DATA, PARITY, STOP: begin
          cnt <= tc_bit ? '0 : cnt + CNT_W'(1);
          if (state == DATA && tc_bit) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= ld_char;
      frame_err  <= ferr_set;
      if (ld_char) char_out <= shreg;
    end
  end

`ifdef CHAR_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`else
  logic unused_perr;
  assign unused_perr = perr_set;
`endif

endmodule
